imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 17 +
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_decode.sv | 35 +++
 rtl/imm_gen_pipe.sv | 71 +++++++
 tb/tb_imm_gen_pipe.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format select encodings and fixed widths for the immediate generator.
package imm_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [2:0] {
        SEL_I     = 3'd0,
        SEL_S     = 3'd1,
        SEL_B     = 3'd2,
        SEL_U     = 3'd3,
        SEL_J     = 3'd4,
        SEL_IZ    = 3'd5,
        SEL_SHAMT = 3'd6,
        SEL_ILL   = 3'd7
    } imm_sel_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle for the immediate generator pipeline.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction: instruction word + format select -> XLEN immediate.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_sel_e           sel,
    output logic [XLEN-1:0]    imm,
    output logic               err
);

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (sel)
            SEL_I:  imm = XLEN'($signed(instr[31:20]));
            SEL_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            SEL_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            SEL_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
            SEL_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            SEL_IZ: imm = XLEN'(instr[31:20]);
            SEL_SHAMT: begin
                if (XLEN == 64) imm = XLEN'(instr[25:20]);
                else            imm = XLEN'(instr[24:20]);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: stage 1 holds the request, stage 2 the decoded result.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);

    logic               s1_valid;
    logic [INSTR_W-1:0] s1_instr;
    imm_sel_e           s1_sel;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_valid;
    logic [XLEN-1:0]    s2_imm;
    logic [TAG_W-1:0]   s2_tag;
    logic               s2_err;

    logic [XLEN-1:0]    dec_imm;
    logic               dec_err;
    logic               s2_adv;
    logic               s1_adv;

    // A stage may load when its successor is empty or is being drained this cycle.
    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_imm   = s2_imm;
    assign bus.out_tag   = s2_tag;
    assign bus.out_err   = s2_err;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (s1_instr),
        .sel   (s1_sel),
        .imm   (dec_imm),
        .err   (dec_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_imm   <= '0;
            s2_tag   <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= bus.in_valid;
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                s2_imm <= dec_imm;
                s2_tag <= s1_tag;
                s2_err <= dec_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && bus.in_valid) begin
            s1_instr <= bus.in_instr;
            s1_sel   <= imm_sel_e'(bus.in_sel);
            s1_tag   <= bus.in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench driving XLEN=32 and XLEN=64 instances in lockstep against a queue-based reference model.
module tb_imm_gen_pipe;

    logic clk;
    logic rst;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic        err;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] seen_tags[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         now         = 0;
    logic [3:0] tagc        = 4'd0;

    logic        obs_in_ready;
    logic        obs_ov;
    bit          last_acc;
    logic [63:0] last_imm32;
    logic [63:0] last_imm64;
    logic        last_err;
    logic [3:0]  last_tag;

    // Reference: bit fields reassembled with shifts and signed arithmetic, then truncated to xlen.
    function automatic logic [64:0] ref_imm(logic [31:0] ins, logic [2:0] sel, int xlen);
        longint unsigned w = {32'b0, ins};
        longint          v = 0;
        longint unsigned mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (sel)
            3'd0: begin v = longint'((w >> 20) & 64'hFFF); if (v >= 2048) v -= 4096; end
            3'd1: begin
                v = longint'((((w >> 25) & 64'h7F) << 5) | ((w >> 7) & 64'h1F));
                if (v >= 2048) v -= 4096;
            end
            3'd2: begin
                v = longint'((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11)
                    | (((w >> 25) & 64'h3F) << 5) | (((w >> 8) & 64'hF) << 1));
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = longint'(w & 64'hFFFF_F000);
                if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
            end
            3'd4: begin
                v = longint'((((w >> 31) & 1) << 20) | (((w >> 12) & 64'hFF) << 12)
                    | (((w >> 20) & 1) << 11) | (((w >> 21) & 64'h3FF) << 1));
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            3'd5: v = longint'((w >> 20) & 64'hFFF);
            3'd6: v = longint'((w >> 20) & ((xlen == 64) ? 64'h3F : 64'h1F));
            default: return {1'b1, 64'b0};
        endcase
        return {1'b0, 64'(v) & mask};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [3:0] tag, input bit ordy);
        bus32.in_valid = v;  bus64.in_valid = v;
        bus32.in_instr = ins; bus64.in_instr = ins;
        bus32.in_sel = sel;  bus64.in_sel = sel;
        bus32.in_tag = tag;  bus64.in_tag = tag;
        bus32.out_ready = ordy; bus64.out_ready = ordy;
    endtask

    // One clock cycle: called at negedge, checks model against both DUTs, advances the model at posedge.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [3:0] tag, input bit ordy);
        bit          exp_ir;
        bit          exp_ov;
        logic [64:0] r32;
        logic [64:0] r64;
        exp_t        e;
        drive(v, ins, sel, tag, ordy);
        #1;
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && (now - q[0].cyc >= 2);
        obs_in_ready = bus32.in_ready;
        obs_ov       = bus32.out_valid;
        chk("in_ready32", 64'(bus32.in_ready), 64'(exp_ir));
        chk("in_ready64", 64'(bus64.in_ready), 64'(exp_ir));
        chk("out_valid32", 64'(bus32.out_valid), 64'(exp_ov));
        chk("out_valid64", 64'(bus64.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("out_imm32", 64'(bus32.out_imm), q[0].imm32);
            chk("out_imm64", bus64.out_imm, q[0].imm64);
            chk("out_err32", 64'(bus32.out_err), 64'(q[0].err));
            chk("out_err64", 64'(bus64.out_err), 64'(q[0].err));
            chk("out_tag32", 64'(bus32.out_tag), 64'(q[0].tag));
            chk("out_tag64", 64'(bus64.out_tag), 64'(q[0].tag));
            last_imm32 = 64'(bus32.out_imm);
            last_imm64 = bus64.out_imm;
            last_err   = bus32.out_err;
            last_tag   = bus32.out_tag;
        end
        if (bus32.out_valid === 1'b1 && ordy) seen_tags.push_back(bus32.out_tag);
        last_acc = v && exp_ir;
        @(posedge clk);
        if (exp_ov && ordy) void'(q.pop_front());
        if (last_acc) begin
            r32 = ref_imm(ins, sel, 32);
            r64 = ref_imm(ins, sel, 64);
            e.imm32 = r32[63:0];
            e.imm64 = r64[63:0];
            e.err   = r32[64];
            e.tag   = tag;
            e.cyc   = now;
            q.push_back(e);
        end
        now++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 3'($urandom), 4'($urandom), 1'b1);
    endtask

    task automatic apply_reset(input bit v);
        drive(v, $urandom, 3'($urandom), 4'($urandom), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        now++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 4'd0, 1'b0);
        #1;
        chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rst_out_imm32", 64'(bus32.out_imm), 64'd0);
        chk("rst_out_imm64", bus64.out_imm, 64'd0);
        chk("rst_out_tag", 64'(bus32.out_tag), 64'd0);
        chk("rst_out_err", 64'(bus32.out_err), 64'd0);
        chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        #(-1 + 1);
    endtask

    task automatic directed(input string name, input logic [31:0] ins, input logic [2:0] sel,
                            input bit use64, input logic [63:0] exp);
        tagc++;
        cycle(1'b1, ins, sel, tagc, 1'b1);
        cycle(1'b0, 32'd0, 3'd0, 4'd0, 1'b1);
        cycle(1'b0, 32'd0, 3'd0, 4'd0, 1'b1);
        chk(name, use64 ? last_imm64 : last_imm32, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [17:0] ov_hist;
        rst = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        apply_reset(1'b0);

        // Directed formats, XLEN=32
        directed("dir_I32", 32'hFFF0_0093, 3'd0, 1'b0, 64'h0000_0000_FFFF_FFFF);
        directed("dir_S32", 32'hFE20_AE23, 3'd1, 1'b0, 64'h0000_0000_FFFF_FFFC);
        directed("dir_B32", 32'h0000_0463, 3'd2, 1'b0, 64'h0000_0000_0000_0008);
        directed("dir_U32", 32'h1234_50B7, 3'd3, 1'b0, 64'h0000_0000_1234_5000);
        directed("dir_J32", 32'hFFDF_F06F, 3'd4, 1'b0, 64'h0000_0000_FFFF_FFFC);
        // Directed formats, XLEN=64
        directed("dir_U64", 32'h8000_00B7, 3'd3, 1'b1, 64'hFFFF_FFFF_8000_0000);
        directed("dir_SHAMT64", 32'h03F0_0013, 3'd6, 1'b1, 64'h0000_0000_0000_003F);
        directed("dir_IZ64", 32'hFFF0_0093, 3'd5, 1'b1, 64'h0000_0000_0000_0FFF);

        // Illegal select keeps the tag
        cycle(1'b1, 32'hDEAD_BEEF, 3'd7, 4'hA, 1'b1);
        idle(2);
        chk("ill_imm", last_imm64, 64'd0);
        chk("ill_err", 64'(last_err), 64'd1);
        chk("ill_tag", 64'(last_tag), 64'hA);

        // Back-pressure: tags 1..6, consumer stalled for the first 4 cycles
        seen_tags.delete();
        t = 1;
        for (int c = 0; c < 40 && t <= 6; c++) begin
            cycle(1'b1, $urandom, 3'($urandom_range(0, 6)), 4'(t), c >= 4);
            if (c == 2) chk("bp_in_ready_drop", 64'(obs_in_ready), 64'd0);
            if (last_acc) t++;
        end
        chk("bp_all_accepted", 64'(t), 64'd7);
        idle(4);
        chk("bp_tag_count", 64'(seen_tags.size()), 64'd6);
        for (int i = 0; i < 6 && i < seen_tags.size(); i++)
            chk("bp_tag_order", 64'(seen_tags[i]), 64'(i + 1));

        // Reset with both stages full
        cycle(1'b1, $urandom, 3'd0, 4'hC, 1'b0);
        cycle(1'b1, $urandom, 3'd1, 4'hD, 1'b0);
        apply_reset(1'b1);
        seen_tags.delete();
        idle(4);
        chk("rst_no_stale", 64'(seen_tags.size()), 64'd0);

        // Full throughput: 16 back-to-back requests
        ov_hist = '0;
        for (int i = 0; i < 18; i++) begin
            cycle(i < 16, $urandom, 3'($urandom), 4'(i), 1'b1);
            ov_hist[i] = obs_ov;
        end
        chk("tput_pattern", 64'(ov_hist), 64'h3FFFC);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom), 4'($urandom),
                  $urandom_range(0, 9) < 7);
        idle(4);
        chk("final_drain", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
